// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch unit.
// Opcode encodings live in the existing shared opcode defines; only the
// field widths are declared here.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 6;
  localparam int FETCH_INS_W  = 13;
  localparam int OPC_W        = 5;
  localparam int OPR_W        = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch unit: reset to 0, increment on load,
// wrap or stick at the last address depending on WRAP_HALT.
// Optional macro FETCH_JUMP_EN adds a jump load that overrides everything.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int WRAP_HALT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
`ifdef FETCH_JUMP_EN
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_tgt,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              at_end
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;

  assign at_end = (pc == PC_LAST);

  // PC update: jump has priority, then increment; in halt mode the last
  // address is never stepped past
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end
`ifdef FETCH_JUMP_EN
    else if (jump) begin
      pc <= jump_tgt;
    end
`endif
    else if (load && !((WRAP_HALT != 0) && at_end)) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads program memory at PC, holds one
// instruction with a valid/ready handshake toward the decoder.
// Optional macro FETCH_JUMP_EN adds jump_req/jump_tgt ports.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int INS_W     = FETCH_INS_W,
  parameter int WRAP_HALT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [INS_W-1:0]  pm_ins,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [OPR_W-1:0]  operand,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
`ifdef FETCH_JUMP_EN
  ,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_tgt
`endif
);

  fetch_state_t state, state_nxt;
  logic         vld_nxt;
  logic         load;
  logic         jump;
  logic         pc_end;
  logic [ADDR_W-1:0] pc;

`ifdef FETCH_JUMP_EN
  assign jump = jump_req;
`else
  assign jump = 1'b0;
`endif

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .WRAP_HALT(WRAP_HALT)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
`ifdef FETCH_JUMP_EN
    .jump    (jump),
    .jump_tgt(jump_tgt),
`endif
    .pc      (pc),
    .at_end  (pc_end)
  );

  assign pm_addr = pc;
  assign halted  = (state == ST_HALT);

  // Next state: jump flushes, otherwise load when the holding slot is free
  // or being emptied this cycle, otherwise retire a completed handshake
  always_comb begin
    state_nxt = state;
    vld_nxt   = ins_valid;
    load      = 1'b0;
    if (jump) begin
      state_nxt = ST_EMPTY;
      vld_nxt   = 1'b0;
    end else if (en && (state != ST_HALT) && (!ins_valid || ins_ready)) begin
      load      = 1'b1;
      vld_nxt   = 1'b1;
      state_nxt = ((WRAP_HALT != 0) && pc_end) ? ST_HALT : ST_FULL;
    end else if (ins_valid && ins_ready) begin
      vld_nxt = 1'b0;
      if (state != ST_HALT) state_nxt = ST_EMPTY;
    end
  end

  // Control registers: state and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ins_valid <= vld_nxt;
    end
  end

  // Held instruction and its fetch address, captured on load only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= '0;
      operand <= '0;
      pc_out  <= '0;
    end else if (load) begin
      opcode  <= pm_ins[OPR_W +: OPC_W];
      operand <= pm_ins[OPR_W-1:0];
      pc_out  <= pc;
    end
  end

endmodule
